xor_frame_checksum: RTL and testbench

XOR_FRAME_CHECKSUM -- requirements
Module: xor_frame_checksum

---
 rtl/xor_frame_checksum.sv | 155 +++++++++++++++
 tb/tb_xor_frame_checksum.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_frame_checksum.sv
// xor_frame_checksum
//   Accumulates the bitwise XOR of the words of a frame and reports it, with
//   the word count and an overflow flag, once the last word is accepted.
//   The result is held on the output until the consumer takes it.
//
//   Optional build macro: XOR_FRAME_CHECKSUM_PARITY_EN adds out_parity.
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   in_valid      input word valid
//   in_ready      block can accept an input word
//   in_data       input word [WIDTH-1:0]
//   in_last       input word is the last of its frame
//   out_valid     result valid
//   out_ready     consumer accepts the result
//   out_sum       XOR of all words of the frame [WIDTH-1:0]
//   out_count     words in the frame, saturating at MAX_WORDS [CW-1:0]
//   out_overflow  frame had more than MAX_WORDS words
//   out_parity    XOR-reduction of out_sum (macro builds only)
module xor_frame_checksum #(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16,
    localparam int CW       = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CW-1:0]    out_count,
`ifdef XOR_FRAME_CHECKSUM_PARITY_EN
    output logic             out_parity,
`endif
    output logic             out_overflow
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             load;
    logic             ready_en_q;
    logic             accept;

    // ready_en_q keeps in_ready low during reset and until the first clock
    // edge after reset is released.
    assign in_ready  = ready_en_q && (state_q != HOLD);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d = in_data;
                    cnt_d = ONE_CNT;
                    ovf_d = 1'b0;
                    if (in_last) begin
                        state_d = HOLD;
                        load    = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = acc_q ^ in_data;
                    // A word arriving with the count already saturated means
                    // the frame is longer than MAX_WORDS.
                    if (cnt_q == MAX_CNT) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE_CNT;
                    end
                    if (in_last) begin
                        state_d = HOLD;
                        load    = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            ready_en_q <= 1'b1;
        end
    end

    // Result registers load from the post-update accumulator so the result
    // appears on the cycle after the last word is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else if (load) begin
            out_sum      <= acc_d;
            out_count    <= cnt_d;
            out_overflow <= ovf_d;
        end
    end

`ifdef XOR_FRAME_CHECKSUM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
        end else if (load) begin
            out_parity <= ^acc_d;
        end
    end
`endif

endmodule

// File: tb/tb_xor_frame_checksum.sv
// Testbench for xor_frame_checksum (WIDTH=8, MAX_WORDS=16).
// A driver issues frames and pushes the expected result, computed from the
// list of words of each frame, into a queue; a monitor on the falling edge
// pops and compares whenever the DUT presents a result.
module tb_xor_frame_checksum;

    localparam int WIDTH     = 8;
    localparam int MAX_WORDS = 16;
    localparam int CW        = $clog2(MAX_WORDS + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [CW-1:0]    out_count;
    logic             out_overflow;
`ifdef XOR_FRAME_CHECKSUM_PARITY_EN
    logic             out_parity;
`endif

    xor_frame_checksum #(
        .WIDTH    (WIDTH),
        .MAX_WORDS(MAX_WORDS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_count   (out_count),
`ifdef XOR_FRAME_CHECKSUM_PARITY_EN
        .out_parity  (out_parity),
`endif
        .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] sum;
        int               count;
        logic             ovf;
        int               cyc;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] frame_words[$];
    int               tests = 0;
    int               fails = 0;
    int               cyc   = 0;
    bit               rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: result of a frame is the XOR of its words, count saturates
    // at MAX_WORDS, overflow when the frame is longer than MAX_WORDS.
    task automatic close_frame();
        exp_t e;
        e.sum = '0;
        foreach (frame_words[i]) e.sum = e.sum ^ frame_words[i];
        e.count = (frame_words.size() > MAX_WORDS) ? MAX_WORDS : frame_words.size();
        e.ovf   = (frame_words.size() > MAX_WORDS);
        e.cyc   = cyc;
        exp_q.push_back(e);
        frame_words.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_word(input logic [WIDTH-1:0] d, input logic last);
        int   budget;
        logic rdy;
        budget   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        rdy      = in_ready;
        @(posedge clk); #1;
        while (!rdy) begin
            budget++;
            if (budget > 200) begin
                chk("accept_timeout", 64'(rdy), 64'd1);
                in_valid = 1'b0;
                return;
            end
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            rdy = in_ready;
            @(posedge clk); #1;
        end
        frame_words.push_back(d);
        if (last) close_frame();
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int budget;
        budget    = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while ((exp_q.size() != 0 || out_valid) && budget < 100) begin
            budget++;
            @(posedge clk); #1;
        end
        chk("results_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_sum"}, 64'(out_sum), 64'd0);
        chk({tag, "_out_count"}, 64'(out_count), 64'd0);
        chk({tag, "_out_overflow"}, 64'(out_overflow), 64'd0);
`ifdef XOR_FRAME_CHECKSUM_PARITY_EN
        chk({tag, "_out_parity"}, 64'(out_parity), 64'd0);
`endif
    endtask

    // Monitor
    initial begin
        exp_t cur;
        exp_t last_res;
        bit   have_cur;
        bit   have_last;
        bit   just_cons;
        have_cur  = 1'b0;
        have_last = 1'b0;
        just_cons = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                have_cur  = 1'b0;
                have_last = 1'b0;
                just_cons = 1'b0;
            end else begin
                if (!out_valid && have_last) begin
                    chk("hold_out_sum", 64'(out_sum), 64'(last_res.sum));
                    chk("hold_out_count", 64'(out_count), 64'(last_res.count));
                end
                if (just_cons) begin
                    chk("valid_one_cycle", 64'(out_valid), 64'd0);
                    just_cons = 1'b0;
                end else if (out_valid) begin
                    if (!have_cur) begin
                        if (exp_q.size() == 0) begin
                            chk("spurious_result", 64'(out_valid), 64'd0);
                        end else begin
                            cur = exp_q.pop_front();
                            have_cur = 1'b1;
                            chk("latency_cycle", 64'(cyc), 64'(cur.cyc));
                        end
                    end
                    if (have_cur) begin
                        chk("out_sum", 64'(out_sum), 64'(cur.sum));
                        chk("out_count", 64'(out_count), 64'(cur.count));
                        chk("out_overflow", 64'(out_overflow), 64'(cur.ovf));
`ifdef XOR_FRAME_CHECKSUM_PARITY_EN
                        chk("out_parity", 64'(out_parity), 64'(^cur.sum));
`endif
                        chk("in_ready_in_hold", 64'(in_ready), 64'd0);
                        if (out_ready) begin
                            have_cur  = 1'b0;
                            just_cons = 1'b1;
                            have_last = 1'b1;
                            last_res  = cur;
                        end
                    end
                end
            end
        end
    end

    // Driver
    initial begin
        int len;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("ready_low_before_edge", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("ready_after_edge", 64'(in_ready), 64'd1);

        // Three-word frame, consumer always ready
        out_ready = 1'b1;
        send_word(8'h0F, 1'b0);
        send_word(8'hF0, 1'b0);
        send_word(8'h3C, 1'b1);
        idle(3);

        // Single-word frame
        send_word(8'hA5, 1'b1);
        idle(3);

        // Result held back for 5 cycles while a word is offered
        out_ready = 1'b0;
        send_word(8'h12, 1'b0);
        send_word(8'h34, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h77;
        in_last  = 1'b1;
        repeat (5) begin
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send_word(8'h77, 1'b1);
        idle(3);

        // Overflow: 18 words of 0x01
        for (int i = 0; i < 18; i++) send_word(8'h01, (i == 17));
        idle(3);
        drain();

        // Reset mid-frame
        send_word(8'hDE, 1'b0);
        send_word(8'hAD, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        frame_words.delete();
        #1 check_reset_outputs("midframe_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_word(8'h55, 1'b1);
        idle(3);

        // in_valid toggling on each cycle
        send_word(8'h01, 1'b0); idle(1);
        send_word(8'h02, 1'b0); idle(1);
        send_word(8'h04, 1'b0); idle(1);
        send_word(8'h08, 1'b1); idle(3);
        drain();

        // Randomized frames with random gaps and random consumer backpressure
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 19);
            if (len >= 17) len++;
            for (int w = 0; w < len; w++) begin
                send_word(8'($urandom), (w == len - 1));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        rand_ready = 1'b0;
        drain();
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
